// File: rtl/seg_pkg.sv
//============================================================================
// seg_pkg : glyph constants and FSM state type for seven-segment readback
// Rev 1.0
//============================================================================
`default_nettype none

package seg_pkg;

    // Lit-segment patterns (bit0..6 = a..g, 1 = lit) indexed by hex value.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seg_glyph_dec.sv
//============================================================================
// seg_glyph_dec : active-low 7-segment pattern -> {hex, blank, err}
// Rev 1.0
//============================================================================
`default_nettype none

module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] hex,
    output logic       blank,
    output logic       err
);

    logic [6:0] lit;
    assign lit = ~pattern;

    always_comb begin
        hex   = 4'h0;
        blank = 1'b0;
        err   = 1'b1;
        if (lit == SEG_BLANK) begin
            blank = 1'b1;
            err   = 1'b0;
        end else begin
            for (int g = 0; g < 16; g++) begin
                if (lit == GLYPHS[g]) begin
                    hex = 4'(g);
                    err = 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_readback.sv
//============================================================================
// seg_readback : samples the seven-segment bus, emits one decoded frame per
// settled change. Define SEG_READBACK_DP_EN to include decimal points.
// Rev 1.0
//============================================================================
`default_nettype none

module seg_readback
    import seg_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG*8-1:0] seg_bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NDIG*4-1:0] out_hex,
    output logic [NDIG-1:0]   out_blank,
    output logic [NDIG-1:0]   out_err,
    output logic [2:0]        out_dp_idx,
    output logic              out_dp_any,
    output logic              out_overrun
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYC);
`ifdef SEG_READBACK_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif
    localparam logic [7:0]        DIG_MASK = DP_EN ? 8'hFF : 8'h7F;
    localparam logic [NDIG*8-1:0] CMP_MASK = {NDIG{DIG_MASK}};

    state_t              state;
    logic [NDIG*8-1:0]   bus_m;
    logic [NDIG*8-1:0]   snap;
    logic [NDIG*8-1:0]   last;
    logic [CW-1:0]       cnt;
    logic                pend_ovr;

    logic [NDIG*4-1:0]   dec_hex;
    logic [NDIG-1:0]     dec_blank;
    logic [NDIG-1:0]     dec_err;
    logic [2:0]          dec_dp_idx;
    logic                dec_dp_any;

    assign bus_m = seg_bus & CMP_MASK;

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_dig
            seg_glyph_dec u_dec (
                .pattern (snap[8*i +: 7]),
                .hex     (dec_hex[4*i +: 4]),
                .blank   (dec_blank[i]),
                .err     (dec_err[i])
            );
        end
    endgenerate

    // Downward scan so the lowest lit dp wins.
    always_comb begin
        dec_dp_any = 1'b0;
        dec_dp_idx = 3'd0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (DP_EN && !snap[8*i+7]) begin
                dec_dp_any = 1'b1;
                dec_dp_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            snap        <= '0;
            last        <= CMP_MASK;   // all-ones within the compared bits
            cnt         <= '0;
            pend_ovr    <= 1'b0;
            out_valid   <= 1'b0;
            out_hex     <= '0;
            out_blank   <= '0;
            out_err     <= '0;
            out_dp_idx  <= 3'd0;
            out_dp_any  <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_m != last) begin
                        state <= SETTLE;
                        snap  <= bus_m;
                        cnt   <= CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt >= CNT_TOP) begin
                        out_hex     <= dec_hex;
                        out_blank   <= dec_blank;
                        out_err     <= dec_err;
                        out_dp_idx  <= dec_dp_idx;
                        out_dp_any  <= dec_dp_any;
                        out_overrun <= pend_ovr;
                        pend_ovr    <= 1'b0;
                        out_valid   <= 1'b1;
                        last        <= snap;
                        state       <= OUT;
                    end else if (bus_m != snap) begin
                        snap <= bus_m;
                        cnt  <= CW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_overrun <= 1'b0;
                        if (bus_m != last) begin
                            state <= SETTLE;
                            snap  <= bus_m;
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus_m != last) begin
                        pend_ovr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
